// File: rtl/hdlc_pkg.sv
// Shared state encoding, window entry type and line constants for the HDLC receive path.
package hdlc_pkg;

  typedef enum logic [1:0] {
    HUNT,
    OPEN,
    DATA
  } state_t;

  localparam logic [7:0] FLAG_PATTERN = 8'h7E;
  localparam logic [2:0] STUFF_ONES   = 3'd5;
  localparam logic [2:0] ABORT_ONES   = 3'd7;
  localparam int         WIN_LEN      = 8;

  // One slot of the detection window: the raw line bit and whether the assembler must skip it.
  typedef struct packed {
    logic data;
    logic drop;
  } win_entry_t;

  localparam win_entry_t WIN_EMPTY = '{data: 1'b0, drop: 1'b1};

endpackage

// File: rtl/hdlc_rx_window.sv
// Ones counter and tagged 8-bit detection window: finds flags and aborts, marks stuffed zeros,
// and presents the bit leaving the window to the byte assembler.
module hdlc_rx_window
  import hdlc_pkg::*;
(
  input  logic clk,
  input  logic clear,
  input  logic rx,
  input  logic stuff_en,
  output logic exit_bit,
  output logic exit_drop,
  output logic flag_hit,
  output logic abort_hit
);

  logic [2:0]               ones;
  win_entry_t [WIN_LEN-1:0] win;
  logic [WIN_LEN-1:0]       win_bits;
  logic                     stuff_drop;
  logic                     purge;

  // A zero right after five ones is a stuffed bit, but only once we are inside framing.
  assign stuff_drop = stuff_en && !rx && (ones == STUFF_ONES);
  assign purge      = flag_hit || abort_hit;

  always_ff @(posedge clk) begin
    if (clear) begin
      ones      <= '0;
      abort_hit <= 1'b0;
      // NOTE: the window is reset rather than left as plain storage, because its drop tags are
      // what keep stale line bits out of the assembler after a restart.
      for (int i = 0; i < WIN_LEN; i++) begin
        win[i] <= WIN_EMPTY;
      end
    end else begin
      // NOTE: non-blocking assignments let every slot read its neighbour's pre-edge value,
      // so the shift works regardless of statement order.
      if (!rx) begin
        ones <= '0;
      end else if (ones != ABORT_ONES) begin
        ones <= ones + 3'd1;
      end
      // Fires once on the transition to seven ones; the saturated count cannot re-trigger it.
      abort_hit <= rx && (ones == ABORT_ONES - 3'd1);
      win[0] <= '{data: rx, drop: stuff_drop};
      for (int i = 1; i < WIN_LEN; i++) begin
        win[i] <= '{data: win[i-1].data, drop: win[i-1].drop || purge};
      end
    end
  end

  always_comb begin
    win_bits = '0;
    for (int i = 0; i < WIN_LEN; i++) begin
      win_bits[i] = win[WIN_LEN-1-i].data;
    end
  end

  assign flag_hit  = (win_bits == FLAG_PATTERN);
  assign exit_bit  = win[WIN_LEN-1].data;
  assign exit_drop = win[WIN_LEN-1].drop;

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer top: frame state machine, LSB-first byte assembler and registered
// status pulses, fed by the tagged detection window.
module hdlc_rx_deframer
  import hdlc_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx_Enable,
  input  logic       Rx,
  output logic [7:0] Rx_Data,
  output logic       Rx_NewByte,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_ValidFrame,
  output logic       Rx_EoF,
  output logic       Rx_FrameError
);

  state_t     state;
  state_t     state_nxt;
  logic       clear;
  logic       stuff_en;
  logic       exit_bit;
  logic       exit_drop;
  logic       flag_hit;
  logic       abort_hit;
  logic       data_exit;
  logic       take_bit;
  logic       byte_done;
  logic       close_frame;
  logic       close_err;
  logic       abort_pulse;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       close_q;
  logic       close_err_q;

  assign clear    = Rst || !Rx_Enable;
  assign stuff_en = (state == OPEN) || (state == DATA);

  hdlc_rx_window u_window (
    .clk       (Clk),
    .clear     (clear),
    .rx        (Rx),
    .stuff_en  (stuff_en),
    .exit_bit  (exit_bit),
    .exit_drop (exit_drop),
    .flag_hit  (flag_hit),
    .abort_hit (abort_hit)
  );

  // While a flag sits in the window its oldest bit is leaving; that bit belongs to the flag.
  assign data_exit = !exit_drop && !flag_hit;

  always_ff @(posedge Clk) begin
    if (clear) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT: begin
        if (flag_hit) state_nxt = OPEN;
      end
      OPEN: begin
        if (flag_hit)       state_nxt = OPEN;
        else if (abort_hit) state_nxt = HUNT;
        else if (data_exit) state_nxt = DATA;
      end
      DATA: begin
        if (flag_hit)       state_nxt = OPEN;
        else if (abort_hit) state_nxt = HUNT;
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    take_bit    = 1'b0;
    close_frame = 1'b0;
    close_err   = 1'b0;
    abort_pulse = 1'b0;
    case (state)
      OPEN: begin
        take_bit    = data_exit && !abort_hit;
        abort_pulse = abort_hit;
      end
      DATA: begin
        // An abort is registered one stage late, so the bit leaving now is still real data.
        take_bit    = data_exit;
        close_frame = flag_hit || abort_hit;
        close_err   = abort_hit || (bit_cnt != 3'd0);
        abort_pulse = abort_hit;
      end
      default: ;
    endcase
  end

  assign byte_done = take_bit && (bit_cnt == 3'd7);

  always_ff @(posedge Clk) begin
    if (clear) begin
      shreg          <= '0;
      bit_cnt        <= '0;
      Rx_Data        <= '0;
      Rx_NewByte     <= 1'b0;
      Rx_FlagDetect  <= 1'b0;
      Rx_AbortDetect <= 1'b0;
      Rx_ValidFrame  <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_FrameError  <= 1'b0;
      close_q        <= 1'b0;
      close_err_q    <= 1'b0;
    end else begin
      if (take_bit) begin
        shreg <= {exit_bit, shreg[7:1]};
      end
      // Outside DATA the counter is held at zero, so the first data bit counts as bit 0.
      if (state_nxt != DATA) begin
        bit_cnt <= '0;
      end else if (take_bit) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      Rx_NewByte <= byte_done;
      if (byte_done) begin
        Rx_Data <= {exit_bit, shreg[7:1]};
      end
      Rx_FlagDetect  <= flag_hit;
      Rx_AbortDetect <= abort_pulse;
      Rx_ValidFrame  <= (state_nxt == DATA);
      close_q        <= close_frame;
      close_err_q    <= close_err;
      Rx_EoF         <= close_q;
      Rx_FrameError  <= close_q && close_err_q;
    end
  end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Directed bench for hdlc_rx_deframer: stimulus pushes expected events with their cycle,
// a negedge monitor pops and compares whenever the deframer reports something.
module tb_hdlc_rx_deframer;

  logic       clk;
  logic       rst;
  logic       rx_en;
  logic       rx;
  logic [7:0] rx_data;
  logic       new_byte;
  logic       flag_det;
  logic       abort_det;
  logic       valid_frame;
  logic       eof;
  logic       frame_err;

  hdlc_rx_deframer dut (
    .Clk            (clk),
    .Rst            (rst),
    .Rx_Enable      (rx_en),
    .Rx             (rx),
    .Rx_Data        (rx_data),
    .Rx_NewByte     (new_byte),
    .Rx_FlagDetect  (flag_det),
    .Rx_AbortDetect (abort_det),
    .Rx_ValidFrame  (valid_frame),
    .Rx_EoF         (eof),
    .Rx_FrameError  (frame_err)
  );

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         cyc;
  } exp_t;

  typedef enum int {EV_BYTE, EV_FLAG, EV_ABORT, EV_EOF, EV_RISE} ev_t;

  exp_t byte_q[$];
  exp_t flag_q[$];
  exp_t abort_q[$];
  exp_t eof_q[$];
  exp_t rise_q[$];
  exp_t mon_e;

  localparam logic [7:0] FLAG = 8'h7E;

  int   cyc         = 0;
  int   last_k      = 0;
  int   data_k      = 0;
  int   tx_ones     = 0;
  int   n_checks    = 0;
  int   n_fail      = 0;
  int   vf_fall_cyc = -100;
  logic prev_vf     = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cyc = number of rising edges so far; an output registered at edge n is seen with cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input ev_t kind, input logic [7:0] d, input logic err, input int c);
    exp_t e;
    e.data = d;
    e.err  = err;
    e.cyc  = c;
    case (kind)
      EV_BYTE:  byte_q.push_back(e);
      EV_FLAG:  flag_q.push_back(e);
      EV_ABORT: abort_q.push_back(e);
      EV_EOF:   eof_q.push_back(e);
      default:  rise_q.push_back(e);
    endcase
  endtask

  // Bit is driven at a falling edge and sampled at the next rising edge, edge number cyc+1.
  task automatic drive_bit(input logic b);
    @(negedge clk);
    rx     = b;
    last_k = cyc + 1;
  endtask

  task automatic send_data_bit(input logic b);
    drive_bit(b);
    data_k = last_k;
    if (b) tx_ones++;
    else   tx_ones = 0;
    if (tx_ones == 5) begin
      drive_bit(1'b0);
      tx_ones = 0;
    end
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = FLAG;
    for (int i = 0; i < 8; i++) drive_bit(f[i]);
    tx_ones = 0;
    expect_ev(EV_FLAG, 8'h00, 1'b0, last_k + 1);
  endtask

  task automatic close_flag(input logic err);
    send_flag();
    expect_ev(EV_EOF, 8'h00, err, last_k + 2);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic first);
    for (int i = 0; i < 8; i++) begin
      send_data_bit(b[i]);
      if (first && i == 0) expect_ev(EV_RISE, 8'h00, 1'b0, data_k + 8);
      if (first && i == 7) check("no_frame_before_data_exit", 32'(valid_frame), 32'd0);
    end
    expect_ev(EV_BYTE, b, 1'b0, data_k + 8);
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_abort(input logic in_frame);
    send_ones(7);
    expect_ev(EV_ABORT, 8'h00, 1'b0, last_k + 1);
    if (in_frame) expect_ev(EV_EOF, 8'h00, 1'b1, last_k + 2);
  endtask

  // Opens a frame, leaves it mid-byte, then kills it with Rst or Rx_Enable.
  task automatic kill_mid_frame(input logic use_rst);
    logic [11:0] pat;
    pat = 12'h681;
    send_flag();
    for (int i = 0; i < 12; i++) begin
      send_data_bit(pat[i]);
      if (i == 0) expect_ev(EV_RISE, 8'h00, 1'b0, data_k + 8);
    end
    check("frame_open_before_kill", 32'(valid_frame), 32'd1);
    @(negedge clk);
    rx = 1'b1;
    if (use_rst) rst = 1'b1;
    else         rx_en = 1'b0;
    @(negedge clk);
    check("kill_valid_frame", 32'(valid_frame), 32'd0);
    check("kill_rx_data", 32'(rx_data), 32'd0);
    check("kill_new_byte", 32'(new_byte), 32'd0);
    check("kill_eof", 32'(eof), 32'd0);
    rst   = 1'b0;
    rx_en = 1'b1;
    tx_ones = 0;
    send_ones(2);
  endtask

  always @(negedge clk) begin
    if (new_byte) begin
      if (byte_q.size() == 0) check("unexpected_new_byte", 32'(new_byte), 32'd0);
      else begin
        mon_e = byte_q.pop_front();
        check("byte_data", 32'(rx_data), 32'(mon_e.data));
        check("byte_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
    if (flag_det) begin
      if (flag_q.size() == 0) check("unexpected_flag", 32'(flag_det), 32'd0);
      else begin
        mon_e = flag_q.pop_front();
        check("flag_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
    if (abort_det) begin
      if (abort_q.size() == 0) check("unexpected_abort", 32'(abort_det), 32'd0);
      else begin
        mon_e = abort_q.pop_front();
        check("abort_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
    if (valid_frame && !prev_vf) begin
      if (rise_q.size() == 0) check("unexpected_frame_rise", 32'(valid_frame), 32'd0);
      else begin
        mon_e = rise_q.pop_front();
        check("frame_rise_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
    if (!valid_frame && prev_vf) vf_fall_cyc = cyc;
    prev_vf = valid_frame;
    if (eof) begin
      if (eof_q.size() == 0) check("unexpected_eof", 32'(eof), 32'd0);
      else begin
        mon_e = eof_q.pop_front();
        check("eof_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("eof_after_frame_fall", 32'(cyc - vf_fall_cyc), 32'd1);
        check("frame_error", 32'(frame_err), 32'(mon_e.err));
      end
    end else if (frame_err) begin
      check("frame_error_without_eof", 32'(frame_err), 32'd0);
    end
  end

  initial begin
    rst   = 1'b1;
    rx_en = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_new_byte", 32'(new_byte), 32'd0);
    check("reset_flag", 32'(flag_det), 32'd0);
    check("reset_abort", 32'(abort_det), 32'd0);
    check("reset_valid_frame", 32'(valid_frame), 32'd0);
    check("reset_eof", 32'(eof), 32'd0);
    check("reset_frame_error", 32'(frame_err), 32'd0);
    rst = 1'b0;

    // Idle ones in HUNT (no abort reported), then an opening flag.
    send_ones(16);
    send_flag();

    // Two clean bytes.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b0);
    close_flag(1'b0);

    // All-ones byte carrying a stuffed zero.
    send_flag();
    send_byte(8'hFF, 1'b1);
    close_flag(1'b0);

    // One byte then an abort inside the next byte.
    send_flag();
    send_byte(8'h12, 1'b1);
    send_abort(1'b1);
    for (int i = 0; i < 8; i++) drive_bit(i[0] == 1'b0);

    // Twelve data bits: one byte plus a discarded nibble.
    tx_ones = 0;
    send_flag();
    send_byte(8'hC3, 1'b1);
    send_data_bit(1'b1);
    send_data_bit(1'b0);
    send_data_bit(1'b1);
    send_data_bit(1'b0);
    close_flag(1'b1);

    // Mid-frame kill by reset, then by Rx_Enable, then a clean frame.
    kill_mid_frame(1'b1);
    kill_mid_frame(1'b0);
    send_flag();
    send_byte(8'h96, 1'b1);
    close_flag(1'b0);

    // Abort while OPEN between frames: pulse, no end of frame.
    send_abort(1'b0);
    send_ones(20);

    check("pending_bytes", 32'(byte_q.size()), 32'd0);
    check("pending_flags", 32'(flag_q.size()), 32'd0);
    check("pending_aborts", 32'(abort_q.size()), 32'd0);
    check("pending_eofs", 32'(eof_q.size()), 32'd0);
    check("pending_frame_rises", 32'(rise_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
